// File: rtl/sub_serial_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives req/x/y; slave returns ack/r/bo.
interface sub_serial_if #(
  parameter int N = 8
);
  logic         req;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         ack;
  logic [N-1:0] r;
  logic         bo;

  modport master (
    output req, x, y,
    input  ack, r, bo
  );

  modport slave (
    input  req, x, y,
    output ack, r, bo
  );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial N-bit subtractor r = x - y, LSB first, one full-subtractor cell.
// Ports: clk, rst (async active-low), bus (req/x/y in, ack/r/bo out).
module sub_serial #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst,
  sub_serial_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nstate;

  logic [N-1:0]  r_xs;
  logic [N-1:0]  r_ys;
  logic [N-1:0]  r_r;
  logic          r_borrow;
  logic          r_bo;
  logic          r_ack;
  logic [CW-1:0] r_cnt;

  logic          w_a;
  logic          w_b;
  logic          w_d;
  logic          w_bnext;
  logic          w_last;
  logic [N-1:0]  w_rnext;

  assign w_a     = r_xs[0];
  assign w_b     = r_ys[0];
  assign w_d     = w_a ^ w_b ^ r_borrow;
  assign w_bnext = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
  assign w_last  = (r_cnt == CW'(N - 1));

  // Difference bits enter at the MSB so bit 0 lands in r[0] after N shifts.
  generate
    if (N == 1) begin : g_one
      assign w_rnext = w_d;
    end else begin : g_many
      assign w_rnext = {w_d, r_r[N-1:1]};
    end
  endgenerate

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE:    if (bus.req) w_nstate = BUSY;
      BUSY:    if (w_last)  w_nstate = DONE;
      DONE:    if (!bus.req) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_xs     <= '0;
      r_ys     <= '0;
      r_r      <= '0;
      r_borrow <= 1'b0;
      r_bo     <= 1'b0;
      r_ack    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_nstate;
      r_ack   <= (w_nstate == DONE);
      unique case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_xs     <= bus.x;
            r_ys     <= bus.y;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          r_r      <= w_rnext;
          r_xs     <= r_xs >> 1;
          r_ys     <= r_ys >> 1;
          r_borrow <= w_bnext;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) r_bo <= w_bnext;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack = r_ack;
  assign bus.r   = r_r;
  assign bus.bo  = r_bo;
endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial at N=1, 8 and 16.
// Reference: {bo,r} = {0,x} - {0,y}; latency N+1 edges from req.
module tb_sub_serial;
  logic clk;
  logic rst;

  sub_serial_if #(.N(1))  b1 ();
  sub_serial_if #(.N(8))  b8 ();
  sub_serial_if #(.N(16)) b16 ();

  sub_serial #(.N(1))  u1  (.clk(clk), .rst(rst), .bus(b1));
  sub_serial #(.N(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
  sub_serial #(.N(16)) u16 (.clk(clk), .rst(rst), .bus(b16));

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drv(input int n, input logic rq,
                     input logic [15:0] a, input logic [15:0] b);
    case (n)
      1: begin b1.req = rq; b1.x = a[0]; b1.y = b[0]; end
      8: begin b8.req = rq; b8.x = a[7:0]; b8.y = b[7:0]; end
      default: begin b16.req = rq; b16.x = a; b16.y = b; end
    endcase
  endtask

  task automatic smp(input int n, output logic ak,
                     output logic [15:0] rr, output logic bb);
    case (n)
      1: begin ak = b1.ack; rr = {15'd0, b1.r}; bb = b1.bo; end
      8: begin ak = b8.ack; rr = {8'd0, b8.r}; bb = b8.bo; end
      default: begin ak = b16.ack; rr = b16.r; bb = b16.bo; end
    endcase
  endtask

  function automatic logic [15:0] ref_r(int n, logic [15:0] a, logic [15:0] b);
    logic [15:0] m;
    m = 16'((32'd1 << n) - 1);
    return (a - b) & m;
  endfunction

  // Called at a negedge; returns at the negedge where ack is first seen.
  task automatic run_op(input int n, input logic [15:0] a, input logic [15:0] b,
                        output int edges, output logic [15:0] rr, output logic bb);
    logic ak;
    drv(n, 1'b1, a, b);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      smp(n, ak, rr, bb);
    end while (!ak && edges < n + 8);
  endtask

  task automatic test_reset;
    logic ak, bb;
    logic [15:0] rr;
    rst = 1'b0;
    drv(1, 1'b0, 16'd0, 16'd0);
    drv(8, 1'b0, 16'd0, 16'd0);
    drv(16, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    smp(8, ak, rr, bb);
    checks++;
    if ({ak, rr, bb} !== 18'd0) begin
      errors++;
      $display("FAIL reset8: ack=%b r=%h bo=%b want 0/0/0", ak, rr, bb);
    end
    smp(16, ak, rr, bb);
    checks++;
    if ({ak, rr, bb} !== 18'd0) begin
      errors++;
      $display("FAIL reset16: ack=%b r=%h bo=%b want 0/0/0", ak, rr, bb);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] xa [4] = '{8'h2A, 8'h05, 8'h00, 8'hA5};
    logic [7:0] ya [4] = '{8'h0F, 8'h07, 8'hFF, 8'hA5};
    logic [15:0] rr, er;
    logic bb, ak;
    int e;
    for (int i = 0; i < 4; i++) begin
      run_op(8, 16'(xa[i]), 16'(ya[i]), e, rr, bb);
      er = ref_r(8, 16'(xa[i]), 16'(ya[i]));
      checks++;
      if (e !== 9) begin
        errors++;
        $display("FAIL basic_lat[%0d]: edges=%0d want 9", i, e);
      end
      checks++;
      if (rr !== er || bb !== (xa[i] < ya[i])) begin
        errors++;
        $display("FAIL basic[%0d]: r=%h bo=%b want %h %b",
                 i, rr, bb, er, xa[i] < ya[i]);
      end
      drv(8, 1'b0, 16'd0, 16'd0);
      @(negedge clk);
      smp(8, ak, rr, bb);
      checks++;
      if (ak !== 1'b0 || rr !== er) begin
        errors++;
        $display("FAIL basic_rel[%0d]: ack=%b r=%h want 0 %h", i, ak, rr, er);
      end
    end
  endtask

  task automatic test_hold_done;
    logic [15:0] rr;
    logic bb, ak;
    int e;
    run_op(8, 16'h0033, 16'h0044, e, rr, bb);
    for (int i = 0; i < 12; i++) begin
      drv(8, 1'b1, 16'($urandom), 16'($urandom));
      @(negedge clk);
      smp(8, ak, rr, bb);
      checks++;
      if (ak !== 1'b1 || rr !== 16'h00EF || bb !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: ack=%b r=%h bo=%b want 1 00ef 1",
                 i, ak, rr, bb);
      end
    end
    drv(8, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
  endtask

  task automatic test_input_change;
    logic [15:0] rr;
    logic bb, ak;
    int e;
    drv(8, 1'b1, 16'h0080, 16'h0001);
    e = 0;
    do begin
      @(negedge clk);
      e++;
      smp(8, ak, rr, bb);
      drv(8, 1'b1, 16'($urandom), 16'($urandom));
    end while (!ak && e < 20);
    checks++;
    if (e !== 9 || rr !== 16'h007F || bb !== 1'b0) begin
      errors++;
      $display("FAIL input_change: edges=%0d r=%h bo=%b want 9 007f 0",
               e, rr, bb);
    end
    drv(8, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
  endtask

  task automatic test_req_drop;
    logic [15:0] rr;
    logic bb, ak;
    int e;
    drv(8, 1'b1, 16'h005A, 16'h0033);
    @(negedge clk);
    drv(8, 1'b0, 16'h00FF, 16'h00FF);
    e = 1;
    do begin
      @(negedge clk);
      e++;
      smp(8, ak, rr, bb);
    end while (!ak && e < 20);
    checks++;
    if (e !== 9 || rr !== 16'h0027 || bb !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: edges=%0d r=%h bo=%b want 9 0027 0",
               e, rr, bb);
    end
    @(negedge clk);
    smp(8, ak, rr, bb);
    checks++;
    if (ak !== 1'b0 || rr !== 16'h0027) begin
      errors++;
      $display("FAIL req_drop_pulse: ack=%b r=%h want 0 0027", ak, rr);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] rr;
    logic bb, ak;
    int e;
    drv(8, 1'b1, 16'h00C3, 16'h0011);
    repeat (5) @(negedge clk);
    drv(8, 1'b0, 16'd0, 16'd0);
    rst = 1'b0;
    #1;
    smp(8, ak, rr, bb);
    checks++;
    if (ak !== 1'b0 || rr !== 16'd0 || bb !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ack=%b r=%h bo=%b want 0 0 0", ak, rr, bb);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(8, 16'h0010, 16'h0001, e, rr, bb);
    checks++;
    if (e !== 9 || rr !== 16'h000F || bb !== 1'b0) begin
      errors++;
      $display("FAIL reset_fresh: edges=%0d r=%h bo=%b want 9 000f 0",
               e, rr, bb);
    end
    drv(8, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
  endtask

  task automatic test_random(input int n, input int ops);
    logic [15:0] m, a, b, er, rr;
    logic eb, bb, ak;
    int e, hold, gap;
    m = 16'((32'd1 << n) - 1);
    for (int i = 0; i < ops; i++) begin
      a = 16'($urandom) & m;
      b = 16'($urandom) & m;
      er = ref_r(n, a, b);
      eb = (a < b);
      run_op(n, a, b, e, rr, bb);
      checks++;
      if (e !== n + 1) begin
        errors++;
        $display("FAIL rnd%0d_lat[%0d]: edges=%0d want %0d", n, i, e, n + 1);
      end
      checks++;
      if (rr !== er || bb !== eb) begin
        errors++;
        $display("FAIL rnd%0d[%0d]: x=%h y=%h r=%h bo=%b want %h %b",
                 n, i, a, b, rr, bb, er, eb);
      end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        drv(n, 1'b1, 16'($urandom), 16'($urandom));
        @(negedge clk);
        smp(n, ak, rr, bb);
        checks++;
        if (ak !== 1'b1 || rr !== er || bb !== eb) begin
          errors++;
          $display("FAIL rnd%0d_hold[%0d]: ack=%b r=%h want 1 %h",
                   n, i, ak, rr, er);
        end
      end
      drv(n, 1'b0, 16'd0, 16'd0);
      gap = $urandom_range(1, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        smp(n, ak, rr, bb);
        checks++;
        if (ak !== 1'b0 || rr !== er || bb !== eb) begin
          errors++;
          $display("FAIL rnd%0d_idle[%0d]: ack=%b r=%h bo=%b want 0 %h %b",
                   n, i, ak, rr, bb, er, eb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_done();
    test_input_change();
    test_req_drop();
    test_reset_mid();
    test_random(8, 400);
    test_random(1, 300);
    test_random(16, 300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
